// File: rtl/data_memory_responder.sv
// data_memory_responder
// Word RAM serving the single-cycle core's loads and stores, plus a store log
// FIFO drained over valid/ready, a saturating store counter and a sticky
// done/fail checker so a run can report its own outcome.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LOG_DEPTH   = 8,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_0064,
    parameter logic [31:0] DONE_VALUE  = 32'd7,
    parameter logic [31:0] IGNORE_ADDR = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [15:0] store_count,
    output logic        done,
    output logic        fail,
    output logic        overflow
);

    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam int unsigned LPW         = $clog2(LOG_DEPTH);
    localparam int unsigned CW          = LPW + 1;
    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    // Storage
    logic [31:0] r_mem     [DEPTH_WORDS];
    log_entry_t  r_log_mem [LOG_DEPTH];

    // Log FIFO control
    logic [LPW-1:0] r_wr_ptr;
    logic [LPW-1:0] r_rd_ptr;
    logic [CW-1:0]  r_log_count;

    // Status registers
    logic [15:0] r_store_count;
    logic        r_done;
    logic        r_fail;
    logic        r_overflow;

    // Decoded request
    logic          w_store;
    logic          w_in_range;
    logic          w_aligned;
    logic [AW-1:0] w_index;
    logic          w_ram_we;

    // FIFO handshake
    logic w_log_empty;
    logic w_log_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Checker decode
    logic w_verdict_open;
    logic w_done_hit;
    logic w_fail_hit;

    // Address decode; a store during reset is treated as if it never happened
    always_comb begin
        w_store    = MemWrite & ~reset;
        w_in_range = (DataAdr < RANGE_BYTES);
        w_aligned  = (DataAdr[1:0] == 2'b00);
        w_index    = DataAdr[AW+1:2];
        w_ram_we   = w_store & w_in_range & w_aligned;
    end

    // Zero-latency load path; out-of-range reads return zero
    always_comb begin
        ReadData = '0;
        if (w_in_range) begin
            ReadData = r_mem[w_index];
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_index] <= WriteData;
        end
    end

    // FIFO handshake; a full log still accepts a store when the head leaves this cycle
    always_comb begin
        w_log_empty = (r_log_count == '0);
        w_log_full  = (r_log_count == CW'(LOG_DEPTH));
        w_pop       = ~w_log_empty & log_ready;
        w_push      = w_store & (~w_log_full | w_pop);
        w_drop      = w_store & w_log_full & ~w_pop;
    end

    // Log entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_log_mem[r_wr_ptr] <= '{addr: DataAdr, data: WriteData};
        end
    end

    // Log pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_log_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + LPW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LPW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_log_count <= r_log_count + CW'(1);
                2'b01:   r_log_count <= r_log_count - CW'(1);
                default: r_log_count <= r_log_count;
            endcase
        end
    end

    // Sticky overflow when a store finds the log full with no pop to make room
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Saturating count of accepted store cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_store_count <= '0;
        end else if (w_store && (r_store_count != COUNT_MAX)) begin
            r_store_count <= r_store_count + 16'(1);
        end
    end

    // Verdict decode; the done address is aligned, so a misaligned store always fails
    always_comb begin
        w_verdict_open = ~r_done & ~r_fail;
        w_done_hit     = w_store & (DataAdr == DONE_ADDR) & (WriteData == DONE_VALUE);
        w_fail_hit     = w_store & ~w_done_hit & ((DataAdr != IGNORE_ADDR) | ~w_aligned);
    end

    // First verdict wins and freezes the checker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_verdict_open) begin
            if (w_done_hit) begin
                r_done <= 1'b1;
            end else if (w_fail_hit) begin
                r_fail <= 1'b1;
            end
        end
    end

    // Head-of-log presentation; payload forced to zero when empty
    always_comb begin
        log_valid = ~w_log_empty;
        log_addr  = '0;
        log_data  = '0;
        if (!w_log_empty) begin
            log_addr = r_log_mem[r_rd_ptr].addr;
            log_data = r_log_mem[r_rd_ptr].data;
        end
    end

    // Status outputs straight from their registers
    always_comb begin
        store_count = r_store_count;
        done        = r_done;
        fail        = r_fail;
        overflow    = r_overflow;
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
// Directed scenarios with hand-computed expectations for the data memory
// responder: load/store, checker verdicts, log FIFO fill/drain and reset.
module tb_data_memory_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [15:0] store_count;
    logic        done;
    logic        fail;
    logic        overflow;

    int checks;
    int errors;

    data_memory_responder dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .store_count (store_count),
        .done        (done),
        .fail        (fail),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store cycle, strobe dropped after the edge
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        MemWrite = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        log_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL reset_log_valid got %0b exp 0", log_valid); end
        checks++; if (store_count !== 16'd0) begin errors++; $display("FAIL reset_store_count got %0d exp 0", store_count); end
        checks++; if ({done, fail, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {done, fail, overflow}); end
        checks++; if ({log_addr, log_data} !== 64'd0) begin errors++; $display("FAIL reset_log_payload got %h exp 0", {log_addr, log_data}); end
    endtask

    task automatic test_load_store();
        apply_reset();
        do_store(32'h10, 32'hDEADBEEF);
        DataAdr = 32'h10; #1;
        checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL load_0x10 got %h exp deadbeef", ReadData); end
        DataAdr = 32'h400; #1;
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL load_out_of_range got %h exp 0", ReadData); end
        do_store(32'h0, 32'h11111111);
        do_store(32'h100, 32'h22222222);
        DataAdr = 32'h0; #1;
        checks++; if (ReadData !== 32'h11111111) begin errors++; $display("FAIL oor_store_alias got %h exp 11111111", ReadData); end
        do_store(32'h12, 32'h33333333);
        DataAdr = 32'h10; #1;
        checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_store got %h exp deadbeef", ReadData); end
        do_store(32'hFC, 32'hCAFEF00D);
        DataAdr = 32'hFC; #1;
        checks++; if (ReadData !== 32'hCAFEF00D) begin errors++; $display("FAIL load_last_word got %h exp cafef00d", ReadData); end
        checks++; if (store_count !== 16'd5) begin errors++; $display("FAIL load_store_count got %0d exp 5", store_count); end
        checks++; if ({done, fail} !== 2'b01) begin errors++; $display("FAIL load_store_verdict got %b exp 01", {done, fail}); end
    endtask

    task automatic test_done();
        apply_reset();
        do_store(32'h60, 32'd3);
        checks++; if ({done, fail} !== 2'b00) begin errors++; $display("FAIL done_ignore_addr got %b exp 00", {done, fail}); end
        do_store(32'h64, 32'd7);
        checks++; if ({done, fail} !== 2'b10) begin errors++; $display("FAIL done_set got %b exp 10", {done, fail}); end
        checks++; if (store_count !== 16'd2) begin errors++; $display("FAIL done_store_count got %0d exp 2", store_count); end
        do_store(32'h20, 32'd1);
        checks++; if ({done, fail} !== 2'b10) begin errors++; $display("FAIL done_frozen got %b exp 10", {done, fail}); end
    endtask

    task automatic test_fail();
        apply_reset();
        do_store(32'h20, 32'd5);
        checks++; if ({done, fail} !== 2'b01) begin errors++; $display("FAIL fail_set got %b exp 01", {done, fail}); end
        do_store(32'h64, 32'd7);
        checks++; if ({done, fail} !== 2'b01) begin errors++; $display("FAIL fail_frozen got %b exp 01", {done, fail}); end
        apply_reset();
        do_store(32'h64, 32'd6);
        checks++; if ({done, fail} !== 2'b01) begin errors++; $display("FAIL fail_wrong_value got %b exp 01", {done, fail}); end
        apply_reset();
        do_store(32'h61, 32'd0);
        checks++; if ({done, fail} !== 2'b01) begin errors++; $display("FAIL fail_misaligned got %b exp 01", {done, fail}); end
    endtask

    task automatic test_overflow();
        apply_reset();
        log_ready = 1'b0;
        MemWrite  = 1'b1;
        DataAdr   = 32'h80;
        WriteData = 32'hA0;
        #1;
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL log_no_bypass got %0b exp 0", log_valid); end
        tick();
        MemWrite = 1'b0;
        checks++; if ({log_valid, log_addr, log_data} !== {1'b1, 32'h80, 32'hA0}) begin errors++; $display("FAIL log_first_entry got %0b %h %h exp 1 80 a0", log_valid, log_addr, log_data); end
        for (int i = 1; i < 8; i++) do_store(32'h80 + 32'(4 * i), 32'hA0 + 32'(i));
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL log_full_no_overflow got %0b exp 0", overflow); end
        do_store(32'hF0, 32'hFF);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL log_overflow got %0b exp 1", overflow); end
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({log_valid, log_addr, log_data} !== {1'b1, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
                errors++;
                $display("FAIL drain_entry_%0d got %0b %h %h exp 1 %h %h", i, log_valid, log_addr, log_data, 32'h80 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            tick();
        end
        checks++; if ({log_valid, log_addr, log_data} !== 65'd0) begin errors++; $display("FAIL drain_empty got %0b %h %h exp 0 0 0", log_valid, log_addr, log_data); end
        log_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        log_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_store(32'hA0 + 32'(4 * i), 32'h100 + 32'(i));
        log_ready = 1'b1;
        do_store(32'hD0, 32'h1D0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_no_overflow got %0b exp 0", overflow); end
        for (int i = 1; i < 9; i++) begin
            logic [31:0] ea;
            logic [31:0] ed;
            ea = (i == 8) ? 32'hD0 : 32'hA0 + 32'(4 * i);
            ed = (i == 8) ? 32'h1D0 : 32'h100 + 32'(i);
            checks++;
            if ({log_valid, log_addr, log_data} !== {1'b1, ea, ed}) begin
                errors++;
                $display("FAIL pushpop_entry_%0d got %0b %h %h exp 1 %h %h", i, log_valid, log_addr, log_data, ea, ed);
            end
            tick();
        end
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL pushpop_count_8 got %0b exp 0", log_valid); end
        log_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        log_ready = 1'b0;
        do_store(32'h60, 32'd3);
        do_store(32'h64, 32'd7);
        do_store(32'h60, 32'd9);
        checks++; if ({done, log_valid, store_count} !== {1'b1, 1'b1, 16'd3}) begin errors++; $display("FAIL premid_state got %0b %0b %0d exp 1 1 3", done, log_valid, store_count); end
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'h10;
        WriteData = 32'h0;
        tick();
        reset    = 1'b0;
        MemWrite = 1'b0;
        #1;
        checks++; if ({log_valid, done, fail, store_count} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin errors++; $display("FAIL mid_reset_state got %0b %0b %0b %0d exp 0 0 0 0", log_valid, done, fail, store_count); end
        checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_reset_ram got %h exp deadbeef", ReadData); end
        do_store(32'h70, 32'h55);
        checks++; if ({log_valid, log_addr, log_data} !== {1'b1, 32'h70, 32'h55}) begin errors++; $display("FAIL refill_entry got %0b %h %h exp 1 70 55", log_valid, log_addr, log_data); end
        tick();
        checks++; if (log_valid !== 1'b1) begin errors++; $display("FAIL refill_hold got %0b exp 1", log_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_store();
        test_done();
        test_fail();
        test_overflow();
        test_back_to_back();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
